// File: rtl/axi4_lite_slave_write.sv
// AXI4-Lite write-channel responder fronting a word-addressed memory port.
// AW and W are collected independently, the address is range/alignment
// checked once both are held, a single memory write is issued, and a B
// response is returned. Only one write is outstanding at a time.
module axi4_lite_slave_write #(
  parameter int                        AXI_ADDR_WIDTH = 64,
  parameter int                        AXI_DATA_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                        MEM_SIZE       = 4096
) (
  input  logic                          clk_i,
  input  logic                          arst_i,
  input  logic                          AW_VALID,
  output logic                          AW_READY,
  input  logic [AXI_ADDR_WIDTH-1:0]     AW_ADDR,
  input  logic [2:0]                    AW_PROT,
  input  logic                          W_VALID,
  output logic                          W_READY,
  input  logic [AXI_DATA_WIDTH-1:0]     W_DATA,
  input  logic [AXI_DATA_WIDTH/8-1:0]   W_STRB,
  output logic                          B_VALID,
  input  logic                          B_READY,
  output logic [1:0]                    B_RESP,
  output logic                          mem_we_o,
  output logic [AXI_ADDR_WIDTH-1:0]     mem_addr_o,
  output logic [AXI_DATA_WIDTH-1:0]     mem_data_o,
  output logic [AXI_DATA_WIDTH/8-1:0]   mem_strb_o,
  input  logic                          mem_ack_i
);

  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam logic [AXI_ADDR_WIDTH-1:0] SIZE_A     = AXI_ADDR_WIDTH'(MEM_SIZE);
  localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = AXI_ADDR_WIDTH'(STRB_W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MEM  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [1:0]                state_q, state_d;
  logic [1:0]                resp_q, resp_d;
  logic                      aw_full, w_full;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_DATA_WIDTH-1:0] data_q;
  logic [STRB_W-1:0]         strb_q;

  logic                      aw_hs, w_hs, b_hs;
  logic                      have_aw, have_w;
  logic [AXI_ADDR_WIDTH-1:0] eval_addr;
  logic                      unused_prot;

  // Window check: no wraparound because the subtraction only happens once
  // the address is known to be at or above the base.
  function automatic logic addr_ok(input logic [AXI_ADDR_WIDTH-1:0] a);
    return (a >= BASE_ADDR) && ((a - BASE_ADDR) < SIZE_A) && ((a & ALIGN_MASK) == '0);
  endfunction

  assign unused_prot = ^AW_PROT;

  assign AW_READY = ~arst_i & (state_q == S_IDLE) & ~aw_full;
  assign W_READY  = ~arst_i & (state_q == S_IDLE) & ~w_full;
  assign B_VALID  = ~arst_i & (state_q == S_RESP);
  assign mem_we_o = ~arst_i & (state_q == S_MEM);
  assign B_RESP   = resp_q;

  assign mem_addr_o = addr_q - BASE_ADDR;
  assign mem_data_o = data_q;
  assign mem_strb_o = strb_q;

  assign aw_hs   = AW_VALID & AW_READY;
  assign w_hs    = W_VALID & W_READY;
  assign b_hs    = B_VALID & B_READY;
  assign have_aw = aw_full | aw_hs;
  assign have_w  = w_full | w_hs;
  // A same-cycle AW handshake has not reached addr_q yet, so check the bus.
  assign eval_addr = aw_hs ? AW_ADDR : addr_q;

  // Next-state and response selection.
  always_comb begin
    state_d = state_q;
    resp_d  = resp_q;
    case (state_q)
      S_IDLE: begin
        if (have_aw && have_w) begin
          if (addr_ok(eval_addr)) begin
            state_d = S_MEM;
          end else begin
            state_d = S_RESP;
            resp_d  = RESP_SLVERR;
          end
        end
      end
      S_MEM: begin
        if (mem_ack_i) begin
          state_d = S_RESP;
          resp_d  = RESP_OKAY;
        end
      end
      S_RESP: begin
        if (B_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, capture flags and holding registers.
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state_q <= S_IDLE;
      resp_q  <= RESP_OKAY;
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      if (b_hs) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
      end else begin
        if (aw_hs) aw_full <= 1'b1;
        if (w_hs)  w_full  <= 1'b1;
      end
      if (aw_hs) addr_q <= AW_ADDR;
      if (w_hs) begin
        data_q <= W_DATA;
        strb_q <= W_STRB;
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_write.sv
// Randomized bench for axi4_lite_slave_write with a transaction-level model.
module tb_axi4_lite_slave_write;

  localparam logic [63:0] BASE = 64'h0000_0000_0001_0000;
  localparam int          MSZ  = 4096;

  logic        clk_i = 1'b0;
  logic        arst_i;
  logic        AW_VALID, AW_READY;
  logic [63:0] AW_ADDR;
  logic [2:0]  AW_PROT;
  logic        W_VALID, W_READY;
  logic [31:0] W_DATA;
  logic [3:0]  W_STRB;
  logic        B_VALID, B_READY;
  logic [1:0]  B_RESP;
  logic        mem_we_o;
  logic [63:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [3:0]  mem_strb_o;
  logic        mem_ack_i;

  int total = 0;
  int bad   = 0;

  axi4_lite_slave_write #(
    .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(32), .BASE_ADDR(BASE), .MEM_SIZE(MSZ)
  ) dut (
    .clk_i(clk_i), .arst_i(arst_i),
    .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR), .AW_PROT(AW_PROT),
    .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA), .W_STRB(W_STRB),
    .B_VALID(B_VALID), .B_READY(B_READY), .B_RESP(B_RESP),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_strb_o(mem_strb_o), .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference rule: legal iff inside [BASE, BASE+MSZ) and word aligned.
  function automatic bit addr_ok(input logic [63:0] a);
    if (a < BASE) return 1'b0;
    if ((a - BASE) >= 64'(MSZ)) return 1'b0;
    return (a % 64'd4) == 64'd0;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // One complete write transaction. Delays are in cycles; ack_dly is the
  // number of mem_we_o cycles before the acknowledging one.
  task automatic do_write(input logic [63:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly,
                          input int ack_dly, input int b_dly, input bit poke_aw);
    bit aw_done = 0, w_done = 0, aw_fire, w_fire;
    bit ok = addr_ok(addr);
    int c = 0;
    logic [1:0] exp_resp = ok ? 2'b00 : 2'b10;
    B_READY = 1'b0;
    while (!(aw_done && w_done)) begin
      if (c > 60) begin
        chk("capture_timeout", 64'd0, 64'd1);
        AW_VALID = 1'b0; W_VALID = 1'b0;
        return;
      end
      AW_VALID  = !aw_done && (c >= aw_dly);
      AW_ADDR   = AW_VALID ? addr : {$urandom, $urandom};
      AW_PROT   = 3'($urandom);
      W_VALID   = !w_done && (c >= w_dly);
      W_DATA    = W_VALID ? data : $urandom;
      W_STRB    = W_VALID ? strb : 4'($urandom);
      mem_ack_i = 1'($urandom_range(0, 1));
      #1;
      chk("idle_we", 64'(mem_we_o), 64'd0);
      chk("idle_bvalid", 64'(B_VALID), 64'd0);
      if (aw_done) chk("aw_ready_held", 64'(AW_READY), 64'd0);
      if (w_done)  chk("w_ready_held", 64'(W_READY), 64'd0);
      aw_fire = AW_VALID && AW_READY;
      w_fire  = W_VALID && W_READY;
      step();
      c++;
      aw_done = aw_done | aw_fire;
      w_done  = w_done | w_fire;
    end
    AW_VALID = 1'b0; W_VALID = 1'b0; mem_ack_i = 1'b0;
    if (ok) begin
      for (int i = 0; i <= ack_dly; i++) begin
        chk("mem_we", 64'(mem_we_o), 64'd1);
        chk("mem_addr", mem_addr_o, addr - BASE);
        chk("mem_data", 64'(mem_data_o), 64'(data));
        chk("mem_strb", 64'(mem_strb_o), 64'(strb));
        chk("mem_bvalid", 64'(B_VALID), 64'd0);
        chk("mem_awready", 64'(AW_READY), 64'd0);
        mem_ack_i = (i == ack_dly);
        step();
      end
      mem_ack_i = 1'b0;
    end
    for (int i = 0; i <= b_dly; i++) begin
      chk("b_valid", 64'(B_VALID), 64'd1);
      chk("b_resp", 64'(B_RESP), 64'(exp_resp));
      chk("resp_we", 64'(mem_we_o), 64'd0);
      chk("resp_awready", 64'(AW_READY), 64'd0);
      chk("resp_wready", 64'(W_READY), 64'd0);
      B_READY   = (i == b_dly);
      AW_VALID  = poke_aw && (i < b_dly);
      AW_ADDR   = {$urandom, $urandom};
      mem_ack_i = 1'($urandom_range(0, 1));
      step();
    end
    B_READY = 1'b0; AW_VALID = 1'b0; mem_ack_i = 1'b0;
    chk("post_bvalid", 64'(B_VALID), 64'd0);
    chk("post_awready", 64'(AW_READY), 64'd1);
    chk("post_wready", 64'(W_READY), 64'd1);
  endtask

  logic [63:0] ra;
  int          sel;

  initial begin
    arst_i = 1'b1; AW_VALID = 1'b0; AW_ADDR = '0; AW_PROT = '0;
    W_VALID = 1'b0; W_DATA = '0; W_STRB = '0; B_READY = 1'b0; mem_ack_i = 1'b0;
    step(); step(); step();
    chk("rst_awready", 64'(AW_READY), 64'd0);
    chk("rst_wready", 64'(W_READY), 64'd0);
    chk("rst_bvalid", 64'(B_VALID), 64'd0);
    chk("rst_we", 64'(mem_we_o), 64'd0);
    chk("rst_bresp", 64'(B_RESP), 64'd0);
    arst_i = 1'b0;
    #1;
    chk("rel_awready", 64'(AW_READY), 64'd1);
    chk("rel_wready", 64'(W_READY), 64'd1);

    do_write(BASE + 64'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0);
    do_write(BASE + 64'h20, 32'h1234_5678, 4'b0011, 3, 0, 3, 0, 0);
    do_write(BASE + 64'(MSZ), 32'hA5A5_A5A5, 4'hF, 0, 0, 0, 0, 0);
    do_write(BASE + 64'h2, 32'h5A5A_5A5A, 4'hF, 1, 0, 0, 0, 0);
    do_write(BASE + 64'h30, 32'hCAFE_F00D, 4'hC, 0, 2, 0, 5, 1);
    do_write(BASE + 64'h0, 32'h0000_0001, 4'hF, 0, 0, 0, 0, 0);
    do_write(BASE + 64'h4, 32'h0000_0002, 4'hF, 0, 0, 0, 0, 0);
    do_write(BASE - 64'h4, 32'h1111_1111, 4'hF, 0, 0, 0, 0, 0);
    do_write(BASE + 64'(MSZ) - 64'h4, 32'h2222_2222, 4'h1, 0, 0, 1, 0, 0);
    do_write(64'hFFFF_FFFF_FFFF_FFFC, 32'h3333_3333, 4'hF, 0, 0, 0, 0, 0);
    do_write(BASE + 64'h8, 32'h4444_4444, 4'h0, 0, 0, 0, 0, 0);

    // Reset while the memory write is pending.
    AW_VALID = 1'b1; AW_ADDR = BASE + 64'h40; W_VALID = 1'b1; W_DATA = 32'h7777_7777;
    W_STRB = 4'hF; mem_ack_i = 1'b0;
    step();
    AW_VALID = 1'b0; W_VALID = 1'b0;
    chk("mid_we", 64'(mem_we_o), 64'd1);
    step();
    arst_i = 1'b1;
    step();
    arst_i = 1'b0;
    #1;
    chk("mid_rst_we", 64'(mem_we_o), 64'd0);
    chk("mid_rst_bvalid", 64'(B_VALID), 64'd0);
    chk("mid_rst_awready", 64'(AW_READY), 64'd1);
    chk("mid_rst_wready", 64'(W_READY), 64'd1);
    step();
    chk("mid_rst_no_b", 64'(B_VALID), 64'd0);
    do_write(BASE + 64'h44, 32'h8888_8888, 4'hF, 0, 0, 0, 0, 0);

    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)       ra = BASE + 64'($urandom_range(0, MSZ / 4 - 1)) * 64'd4;
      else if (sel == 6) ra = BASE + 64'($urandom_range(0, MSZ - 1)) | 64'd1;
      else if (sel == 7) ra = BASE + 64'(MSZ) + 64'($urandom_range(0, 255)) * 64'd4;
      else if (sel == 8) ra = BASE - 64'($urandom_range(1, 64)) * 64'd4;
      else               ra = {$urandom, $urandom};
      do_write(ra, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi4_lite_slave_write.md
Name: axi4_lite_slave_write

Overview:
AXI4-Lite write-channel responder (slave end) that fronts a simple word-addressed memory/peripheral port.
- Accepts AW and W beats independently, in either order or in the same cycle.
- Range- and alignment-checks the address, performs one memory write, then returns a B response.
- Sits between the interconnect and on-chip RAM/MMIO, facing the core's AXI4-Lite master write unit.

Parameters:
AXI_ADDR_WIDTH, 64, address width of AW_ADDR and mem_addr_o.
AXI_DATA_WIDTH, 32, data width; strobe width is AXI_DATA_WIDTH/8.
BASE_ADDR, 64'h0, first byte address decoded by this slave.
MEM_SIZE, 4096, decoded window size in bytes; power of two, at least AXI_DATA_WIDTH/8.

Ports:
clk_i  in  1  clock, all logic on rising edge.
arst_i  in  1  reset; synchronous, active-high.
AW_VALID  in  1  write address valid.
AW_READY  out  1  write address ready.
AW_ADDR  in  AXI_ADDR_WIDTH  write byte address.
AW_PROT  in  3  protection bits; accepted and ignored.
W_VALID  in  1  write data valid.
W_READY  out  1  write data ready.
W_DATA  in  AXI_DATA_WIDTH  write data.
W_STRB  in  AXI_DATA_WIDTH/8  byte strobes.
B_VALID  out  1  response valid.
B_READY  in  1  response ready.
B_RESP  out  2  response: 2'b00 OKAY, 2'b10 SLVERR.
mem_we_o  out  1  memory write request, held until acknowledged.
mem_addr_o  out  AXI_ADDR_WIDTH  byte offset (AW_ADDR - BASE_ADDR).
mem_data_o  out  AXI_DATA_WIDTH  write data.
mem_strb_o  out  AXI_DATA_WIDTH/8  byte enables.
mem_ack_i  in  1  memory accepted the write this cycle.

Behaviour:
- Reset (arst_i high at a clock edge):
  - State goes to IDLE; aw_full and w_full clear.
  - Address, data and strobe holding registers clear to 0.
  - B_RESP register goes to 2'b00.
  - While arst_i is high, AW_READY, W_READY, B_VALID and mem_we_o are forced to 0.
  - Reset mid-transaction drops the transaction silently; no B response is issued.
- Holding registers:
  - AW handshake (AW_VALID & AW_READY) latches AW_ADDR and sets aw_full.
  - W handshake (W_VALID & W_READY) latches W_DATA and W_STRB and sets w_full.
- Ready generation (combinational):
  - AW_READY = (state == IDLE) & ~aw_full.
  - W_READY = (state == IDLE) & ~w_full.
  - Readiness never depends on the other channel's VALID.
- State machine:
  - IDLE: collect AW and W.
    - When both are captured (both already held, or the missing one handshakes this cycle, or both handshake in the same cycle), evaluate the address in that cycle.
    - Address in range and aligned: next state is MEM.
    - Otherwise: next state is RESP with B_RESP = SLVERR.
    - Error evaluation uses the incoming AW_ADDR when the AW handshake is in that same cycle.
  - MEM: mem_we_o = 1, with mem_* driven from the holding registers.
    - On mem_ack_i, next state is RESP with B_RESP = OKAY.
    - mem_ack_i while mem_we_o is 0 is ignored.
  - RESP: B_VALID = 1; B_RESP is held stable until the B handshake.
    - On B_READY, next state is IDLE and aw_full and w_full clear.
    - No new AW or W is accepted until IDLE, so there is one outstanding write.
- Address check:
  - In range: AW_ADDR >= BASE_ADDR and AW_ADDR - BASE_ADDR < MEM_SIZE, using full-width unsigned compare with no wraparound.
  - Aligned: the low log2(AXI_DATA_WIDTH/8) bits are zero.
  - SLVERR writes never assert mem_we_o.
- W_STRB = 0: treated as a legal write and forwarded to the memory unchanged.
- Latency:
  - Last capture to mem_we_o: 1 cycle.
  - mem_ack_i to B_VALID: 1 cycle.
  - Error path, last capture to B_VALID: 1 cycle.
  - B handshake to AW_READY/W_READY high: 1 cycle.

Test Plan:
1. AW (addr BASE+0x10) and W (data 32'hDEADBEEF, strb 4'hF) in the same cycle; mem_ack_i tied 1 -> next cycle mem_we_o=1, mem_addr_o=0x10, mem_data_o=DEADBEEF; following cycle B_VALID=1, B_RESP=00; returns to IDLE after the B handshake.
2. W first (strb 4'b0011), AW arriving 3 cycles later; mem_ack_i delayed 4 cycles -> W_READY=0 after W capture; mem_we_o held high for exactly 4 cycles with stable mem_* outputs; then B_RESP=00.
3. AW at BASE+MEM_SIZE, then AW at BASE+0x2 -> both return B_RESP=2'b10; mem_we_o never asserts.
4. B_READY held low 5 cycles -> B_VALID and B_RESP stable for all 5 cycles; AW_READY=W_READY=0 throughout; a new AW presented meanwhile is accepted only after return to IDLE.
5. arst_i asserted during MEM with mem_ack_i low -> the next cycle is IDLE, mem_we_o=0 and B_VALID=0; a subsequent clean write completes with OKAY.
6. Back-to-back writes to BASE+0x0 and BASE+0x4, with B_READY always 1 and mem_ack_i always 1 -> each completes in 3 cycles from capture to IDLE, in order, with the correct data at each offset.
